mini_cpu_mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters.
  - Master 0 is the mini CPU data/fetch port.
  - Master 1 is the debug/program-loader port.
- Grants at most one transfer per cycle.
- Uses round-robin priority with a bounded hold limit, so neither master can starve the other.
- Sits between the CPU core and program/data memory inside the mini CPU top level.

---
 rtl/mini_cpu_mem_arbiter_if.sv | 51 +++++
 rtl/mini_cpu_mem_arbiter.sv | 119 +++++++++++
 tb/tb_mini_cpu_mem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mini_cpu_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the shared single-port RAM.
interface mini_cpu_mem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [1:0]    owner;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner
  );

  // Requester / memory environment side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner
  );
endinterface

// File: rtl/mini_cpu_mem_arbiter.sv
// Two-master round-robin arbiter for one single-port synchronous RAM, with a
// bounded hold so a streaming master cannot starve the other one.
module mini_cpu_mem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mini_cpu_mem_arbiter_if.slave bus
);
  localparam int unsigned HCW = 4;
  localparam logic [HCW-1:0] HOLD_LIMIT = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_SAT   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;     // 1 = master 1 held the last grant
  logic [HCW-1:0]  hold_q, hold_d;
  logic            rvalid0_q, rvalid0_d;
  logic            rvalid1_q, rvalid1_d;
  logic            gnt0_c, gnt1_c;
  logic [HCW-1:0]  hold_inc;

  assign hold_inc = (hold_q == HOLD_SAT) ? HOLD_SAT : hold_q + HCW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      hold_q    <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  // Grant decision, next state, hold counter and read-response tracking
  always_comb begin
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    state_d   = S_IDLE;
    last_d    = last_q;
    hold_d    = '0;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;

    if (!rst) begin
      unique case (state_q)
        S_OWN0: begin
          if (bus.m0_req && (!bus.m1_req || hold_q < HOLD_LIMIT)) gnt0_c = 1'b1;
          else if (bus.m1_req)                                    gnt1_c = 1'b1;
        end
        S_OWN1: begin
          if (bus.m1_req && (!bus.m0_req || hold_q < HOLD_LIMIT)) gnt1_c = 1'b1;
          else if (bus.m0_req)                                    gnt0_c = 1'b1;
        end
        default: begin
          if (bus.m0_req && bus.m1_req) begin
            gnt0_c = last_q;
            gnt1_c = !last_q;
          end else begin
            gnt0_c = bus.m0_req;
            gnt1_c = bus.m1_req;
          end
        end
      endcase
    end

    if (gnt0_c) begin
      state_d   = S_OWN0;
      last_d    = 1'b0;
      hold_d    = (state_q == S_OWN0) ? hold_inc : HCW'(1);
      rvalid0_d = !bus.m0_we;
    end else if (gnt1_c) begin
      state_d   = S_OWN1;
      last_d    = 1'b1;
      hold_d    = (state_q == S_OWN1) ? hold_inc : HCW'(1);
      rvalid1_d = !bus.m1_we;
    end
  end

  // Memory port follows the granted master, idles at zero otherwise
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {AW{1'b0}};
    bus.mem_wdata = {DW{1'b0}};
    if (gnt0_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.m0_we;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
    end else if (gnt1_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.m1_we;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
    end
  end

  assign bus.m0_gnt    = gnt0_c;
  assign bus.m1_gnt    = gnt1_c;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;
  assign bus.owner     = 2'(state_q);
endmodule

// File: tb/tb_mini_cpu_mem_arbiter.sv
// Directed bench for mini_cpu_mem_arbiter: a RAM environment, a cycle-level
// reference model checked every cycle, and hand-computed literal expectations.
module tb_mini_cpu_mem_arbiter;
  localparam int unsigned AW       = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  mini_cpu_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mini_cpu_mem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Write-first single-port RAM environment
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= bus.mem_we ? bus.mem_wdata : ram[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long it has held it, pending reads
  int            m_owner  = -1;   // -1 idle, else master index
  int            m_last   = 1;
  int            m_streak = 0;
  bit            m_rv [2] = '{0, 0};
  logic [DW-1:0] m_rdata  = '0;
  logic [DW-1:0] m_mem [256];

  function automatic int model_grant();
    bit r [2];
    r[0] = bus.m0_req;
    r[1] = bus.m1_req;
    if (rst) return -1;
    if (m_owner < 0) begin
      if (r[0] && r[1]) return 1 - m_last;
      if (r[0]) return 0;
      if (r[1]) return 1;
      return -1;
    end
    if (r[m_owner] && (!r[1 - m_owner] || m_streak < int'(MAX_HOLD))) return m_owner;
    if (r[1 - m_owner]) return 1 - m_owner;
    return -1;
  endfunction

  // Compare DUT against the model mid-cycle, advance the model at the edge
  initial begin
    int eg;
    logic          we  [2];
    logic [AW-1:0] ad  [2];
    logic [DW-1:0] wd  [2];
    forever begin
      @(negedge clk);
      if (chk_en) begin
        eg = model_grant();
        we[0] = bus.m0_we;    we[1] = bus.m1_we;
        ad[0] = bus.m0_addr;  ad[1] = bus.m1_addr;
        wd[0] = bus.m0_wdata; wd[1] = bus.m1_wdata;
        chk("m0_gnt", 32'(bus.m0_gnt), 32'(eg == 0));
        chk("m1_gnt", 32'(bus.m1_gnt), 32'(eg == 1));
        chk("mem_en", 32'(bus.mem_en), 32'(eg >= 0));
        chk("mem_we", 32'(bus.mem_we), (eg >= 0) ? 32'(we[eg]) : 32'd0);
        chk("mem_addr", 32'(bus.mem_addr), (eg >= 0) ? 32'(ad[eg]) : 32'd0);
        chk("mem_wdata", 32'(bus.mem_wdata), (eg >= 0) ? 32'(wd[eg]) : 32'd0);
        chk("owner", 32'(bus.owner), 32'(m_owner + 1));
        chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(m_rv[0]));
        chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(m_rv[1]));
        if (m_rv[0]) chk("m0_rdata", 32'(bus.m0_rdata), 32'(m_rdata));
        if (m_rv[1]) chk("m1_rdata", 32'(bus.m1_rdata), 32'(m_rdata));
      end
      @(posedge clk);
      if (chk_en) begin
        eg = model_grant();
        we[0] = bus.m0_we;    we[1] = bus.m1_we;
        ad[0] = bus.m0_addr;  ad[1] = bus.m1_addr;
        wd[0] = bus.m0_wdata; wd[1] = bus.m1_wdata;
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (rst) begin
          m_owner  = -1;
          m_last   = 1;
          m_streak = 0;
        end else if (eg < 0) begin
          m_owner  = -1;
          m_streak = 0;
        end else begin
          m_streak = (m_owner == eg) ? ((m_streak < 15) ? m_streak + 1 : 15) : 1;
          m_owner  = eg;
          m_last   = eg;
          if (we[eg]) m_mem[ad[eg]] = wd[eg];
          else begin
            m_rv[eg] = 1'b1;
            m_rdata  = m_mem[ad[eg]];
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with literal expectations
  initial begin
    int seq [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 256; i++) begin
      ram[i]   = '0;
      m_mem[i] = '0;
    end
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    next_cycle();
    chk_en = 1'b1;

    // Reset held with both masters requesting
    bus.m0_req = 1; bus.m1_req = 1;
    bus.m0_addr = 8'h20; bus.m1_addr = 8'h21;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      next_cycle();
    end

    // First tie then sustained contention
    rst = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("contend_m0_gnt", 32'(bus.m0_gnt), 32'(seq[i] == 0));
      chk("contend_m1_gnt", 32'(bus.m1_gnt), 32'(seq[i] == 1));
      if (i == 1) chk("tie_owner", 32'(bus.owner), 32'd1);
      next_cycle();
    end
    bus.m0_req = 0; bus.m1_req = 0;
    next_cycle();

    // Single master write then read-back of the same address
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 8'h10; bus.m0_wdata = 8'hA5;
    @(negedge clk);
    chk("wr_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    next_cycle();
    bus.m0_we = 0;
    @(negedge clk);
    chk("rd_m0_gnt", 32'(bus.m0_gnt), 32'd1);
    next_cycle();
    bus.m0_req = 0;
    @(negedge clk);
    chk("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
    chk("rd_m0_rdata", 32'(bus.m0_rdata), 32'hA5);
    chk("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    next_cycle();

    // Preload 0x00..0x07 with 0x30..0x37
    for (int i = 0; i < 8; i++) begin
      bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 8'(i); bus.m0_wdata = 8'(8'h30 + i);
      next_cycle();
    end
    bus.m0_req = 0; bus.m0_we = 0;

    // Uncontested streaming reads by master 1
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 8'(i);
      end else begin
        bus.m1_req = 0;
      end
      @(negedge clk);
      if (i < 8) chk("stream_m1_gnt", 32'(bus.m1_gnt), 32'd1);
      if (i > 0) begin
        chk("stream_m1_rvalid", 32'(bus.m1_rvalid), 32'd1);
        chk("stream_m1_rdata", 32'(bus.m1_rdata), 32'(8'h30 + i - 1));
      end
      next_cycle();
    end
    @(negedge clk);
    chk("stream_end_rvalid", 32'(bus.m1_rvalid), 32'd0);
    next_cycle();

    // Reset lands on the edge that would have returned a read
    bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 8'h03;
    @(negedge clk);
    chk("rstrd_m1_gnt", 32'(bus.m1_gnt), 32'd1);
    #1;
    rst = 1; bus.m1_req = 0;
    next_cycle();
    @(negedge clk);
    chk("rstrd_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
    next_cycle();
    rst = 0; bus.m0_req = 1; bus.m1_req = 1; bus.m0_we = 0; bus.m0_addr = 8'h05;
    @(negedge clk);
    chk("rstrd_tie_m0", 32'(bus.m0_gnt), 32'd1);
    next_cycle();

    // Reset after master 0 held last grant must still restart priority at master 0
    rst = 1;
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("rst2_tie_m0", 32'(bus.m0_gnt), 32'd1);
    chk("rst2_tie_m1", 32'(bus.m1_gnt), 32'd0);
    next_cycle();
    bus.m0_req = 0; bus.m1_req = 0;
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
